// File: rtl/abs_max_pkg.sv
`timescale 1ns/1ps
// abs_max_pkg
// Shared types and helpers for the streaming absolute-maximum selector.
//   state_t  : frame FSM states (ACCUM collects beats, DONE holds a result)
//   idx_w()  : index width helper, max(1, $clog2(n)), for lane/beat fields
//   abs_mag(): two's-complement magnitude of a w-bit sample, carried in a
//              MAX_W-bit container so one function serves every WIDTH
package abs_max_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The most-negative value maps onto 2^(w-1), which still fits in w
  // unsigned bits, so there is no saturation case to handle.
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] sample,
                                              input int              w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] neg;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    neg  = (~sample + MAX_W'(1)) & mask;
    return sample[w-1] ? neg : (sample & mask);
  endfunction

endpackage

// File: rtl/abs_max_tree.sv
`timescale 1ns/1ps
// abs_max_tree
// Combinational NUM_CH-input reduction selecting the lane with the largest
// magnitude. Pairwise tree: at each level the right-hand node only replaces
// the left-hand one when strictly greater, so ties resolve to the lowest lane.
//   data       : NUM_CH packed signed samples, lane i at [i*WIDTH +: WIDTH]
//   win_sample : winning sample, unmodified
//   win_mag    : its unsigned magnitude
//   win_lane   : its lane index
module abs_max_tree
  import abs_max_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int NUM_CH = 3,
  localparam int LANE_W = idx_w(NUM_CH)
) (
  input  logic [NUM_CH*WIDTH-1:0] data,
  output logic [WIDTH-1:0]        win_sample,
  output logic [WIDTH-1:0]        win_mag,
  output logic [LANE_W-1:0]       win_lane
);

  logic [WIDTH-1:0]  smp  [NUM_CH];
  logic [WIDTH-1:0]  mag  [NUM_CH];
  logic [LANE_W-1:0] lane [NUM_CH];

  // NOTE: every variable written here is fully assigned on entry before any
  // conditional update, so the block can never infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      smp[i]  = data[i*WIDTH +: WIDTH];
      mag[i]  = WIDTH'(abs_mag(MAX_W'(data[i*WIDTH +: WIDTH]), WIDTH));
      lane[i] = LANE_W'(i);
    end
    // Node i absorbs node i+stride; survivors stay at the left index.
    for (int stride = 1; stride < NUM_CH; stride *= 2) begin
      for (int i = 0; i + stride < NUM_CH; i += 2*stride) begin
        if (mag[i+stride] > mag[i]) begin
          smp[i]  = smp[i+stride];
          mag[i]  = mag[i+stride];
          lane[i] = lane[i+stride];
        end
      end
    end
    win_sample = smp[0];
    win_mag    = mag[0];
    win_lane   = lane[0];
  end

endmodule

// File: rtl/abs_max_stream.sv
`timescale 1ns/1ps
// abs_max_stream
// Streaming signed absolute-maximum selector. Each accepted beat carries
// NUM_CH samples; over a frame of up to FRAME_LEN beats (or shorter when
// in_last closes it) the sample with the largest magnitude is reported.
// Ties: lowest lane within a beat, earliest beat across the frame.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : input beat handshake
//   in_data, in_last      : packed samples, early frame close
//   out_valid/out_ready   : result handshake
//   out_sample, out_mag   : winning sample and its magnitude
//   out_lane, out_beat    : where it was found
//   out_len               : beats in the frame (1..FRAME_LEN)
module abs_max_stream
  import abs_max_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int NUM_CH    = 3,
  parameter  int FRAME_LEN = 4,
  localparam int LANE_W    = idx_w(NUM_CH),
  localparam int BEAT_W    = idx_w(FRAME_LEN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_sample,
  output logic [WIDTH-1:0]        out_mag,
  output logic [LANE_W-1:0]       out_lane,
  output logic [BEAT_W-1:0]       out_beat,
  output logic [BEAT_W:0]         out_len
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] cnt_q;
  logic [WIDTH-1:0]  best_sample_q, best_mag_q;
  logic [LANE_W-1:0] best_lane_q;
  logic [BEAT_W-1:0] best_beat_q;

  logic [WIDTH-1:0]  tree_sample, tree_mag;
  logic [LANE_W-1:0] tree_lane;

  logic              accept, frame_end, take;
  logic [WIDTH-1:0]  nxt_sample, nxt_mag;
  logic [LANE_W-1:0] nxt_lane;
  logic [BEAT_W-1:0] nxt_beat;
  logic [BEAT_W:0]   len_next;

  abs_max_tree #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH)
  ) u_tree (
    .data       (in_data),
    .win_sample (tree_sample),
    .win_mag    (tree_mag),
    .win_lane   (tree_lane)
  );

  // In DONE a new beat may enter in the same cycle the result leaves, which
  // is what keeps back-to-back frames free of bubbles.
  assign in_ready  = (state_q == ACCUM) || out_ready;
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  // For FRAME_LEN=1 the counter is pinned at 0, so every beat ends a frame.
  assign frame_end = accept && (in_last || (cnt_q == LAST_BEAT));

  // Beat 0 always loads, so stale accumulator contents never leak forward.
  assign take       = (cnt_q == '0) || (tree_mag > best_mag_q);
  assign nxt_sample = take ? tree_sample : best_sample_q;
  assign nxt_mag    = take ? tree_mag    : best_mag_q;
  assign nxt_lane   = take ? tree_lane   : best_lane_q;
  assign nxt_beat   = take ? cnt_q       : best_beat_q;
  assign len_next   = (BEAT_W+1)'(cnt_q) + (BEAT_W+1)'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (frame_end) state_d = DONE;
      DONE:    if (out_ready && !frame_end) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      best_sample_q <= '0;
      best_mag_q    <= '0;
      best_lane_q   <= '0;
      best_beat_q   <= '0;
      out_sample    <= '0;
      out_mag       <= '0;
      out_lane      <= '0;
      out_beat      <= '0;
      out_len       <= '0;
    end else if (accept) begin
      if (frame_end) begin
        cnt_q      <= '0;
        out_sample <= nxt_sample;
        out_mag    <= nxt_mag;
        out_lane   <= nxt_lane;
        out_beat   <= nxt_beat;
        out_len    <= len_next;
      end else begin
        cnt_q         <= cnt_q + BEAT_W'(1);
        best_sample_q <= nxt_sample;
        best_mag_q    <= nxt_mag;
        best_lane_q   <= nxt_lane;
        best_beat_q   <= nxt_beat;
      end
    end
  end

endmodule

// File: tb/tb_abs_max_stream.sv
`timescale 1ns/1ps
module tb_abs_max_stream;

  localparam int W  = 4, C  = 3, F  = 4;
  localparam int PW = 8, PC = 5, PF = 1;

  typedef struct {
    int sample;
    int mag;
    int lane;
    int beat;
    int len;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (4/3/4)
  logic         in_valid, in_ready, in_last, out_valid, out_ready;
  logic [C*W-1:0] in_data;
  logic [W-1:0] out_sample, out_mag;
  logic [1:0]   out_lane, out_beat;
  logic [2:0]   out_len;

  // Parameter-sweep instance (8/5/1)
  logic           p_in_valid, p_in_ready, p_in_last, p_out_valid, p_out_ready;
  logic [PC*PW-1:0] p_in_data;
  logic [PW-1:0]  p_out_sample, p_out_mag;
  logic [2:0]     p_out_lane;
  logic [0:0]     p_out_beat;
  logic [1:0]     p_out_len;

  abs_max_stream #(.WIDTH(W), .NUM_CH(C), .FRAME_LEN(F)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sample(out_sample), .out_mag(out_mag), .out_lane(out_lane),
    .out_beat(out_beat), .out_len(out_len)
  );

  abs_max_stream #(.WIDTH(PW), .NUM_CH(PC), .FRAME_LEN(PF)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data), .in_last(p_in_last),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_sample(p_out_sample), .out_mag(p_out_mag), .out_lane(p_out_lane),
    .out_beat(p_out_beat), .out_len(p_out_len)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: scan all samples of a frame in arrival order (beat-major,
  // lane-minor); a later sample wins only with a strictly larger |x|.
  function automatic res_t ref_best(input int vals[$], input int nch, input int w);
    res_t r;
    int   best;
    int   x;
    int   m;
    best = -1;
    r.sample = 0; r.mag = 0; r.lane = 0; r.beat = 0; r.len = 0;
    for (int i = 0; i < vals.size(); i++) begin
      x = (vals[i] >= (1 << (w-1))) ? vals[i] - (1 << w) : vals[i];
      m = (x < 0) ? -x : x;
      if (m > best) begin
        best     = m;
        r.sample = vals[i];
        r.mag    = m;
        r.lane   = i % nch;
        r.beat   = i / nch;
      end
    end
    r.len = vals.size() / nch;
    return r;
  endfunction

  function automatic logic [C*W-1:0] pack3(input int a, input int b, input int c);
    return {c[3:0], b[3:0], a[3:0]};
  endfunction

  function automatic logic [C*W-1:0] rand3();
    return {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
  endfunction

  // ---------------- scoreboards ----------------
  res_t exp_q[$];
  res_t p_exp_q[$];
  int   cur[$];
  int   p_vals[$];
  int   cur_beats = 0;
  res_t m_r, p_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur.delete();
      cur_beats = 0;
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("result_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          m_r = exp_q.pop_front();
          check("m_sample", int'(out_sample), m_r.sample);
          check("m_mag",    int'(out_mag),    m_r.mag);
          check("m_lane",   int'(out_lane),   m_r.lane);
          check("m_beat",   int'(out_beat),   m_r.beat);
          check("m_len",    int'(out_len),    m_r.len);
        end
      end
      if (in_valid && in_ready) begin
        for (int l = 0; l < C; l++) cur.push_back(int'(in_data[l*W +: W]));
        cur_beats++;
        if (in_last || cur_beats == F) begin
          exp_q.push_back(ref_best(cur, C, W));
          cur.delete();
          cur_beats = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      p_exp_q.delete();
    end else begin
      if (p_out_valid && p_out_ready) begin
        check("p_result_expected", int'(p_exp_q.size() > 0), 1);
        if (p_exp_q.size() > 0) begin
          p_r = p_exp_q.pop_front();
          check("p_sample", int'(p_out_sample), p_r.sample);
          check("p_mag",    int'(p_out_mag),    p_r.mag);
          check("p_lane",   int'(p_out_lane),   p_r.lane);
          check("p_beat",   int'(p_out_beat),   p_r.beat);
          check("p_len",    int'(p_out_len),    p_r.len);
        end
      end
      if (p_in_valid && p_in_ready) begin
        p_vals.delete();
        for (int l = 0; l < PC; l++) p_vals.push_back(int'(p_in_data[l*PW +: PW]));
        p_exp_q.push_back(ref_best(p_vals, PC, PW));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [C*W-1:0] d, input logic last);
    int   budget;
    logic hs;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    budget   = 0;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!hs && budget < 50);
    check("send_accept", int'(hs), 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic p_send(input logic [PC*PW-1:0] d, input logic last);
    int   budget;
    logic hs;
    p_in_valid = 1'b1;
    p_in_data  = d;
    p_in_last  = last;
    budget     = 0;
    do begin
      @(negedge clk);
      hs = p_in_ready;
      @(posedge clk);
      #1;
      budget++;
      if (!hs) p_out_ready = 1'b1;
    end while (!hs && budget < 50);
    check("p_send_accept", int'(hs), 1);
    p_in_valid = 1'b0;
    p_in_last  = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},  int'(out_valid),  0);
    check({tag, "_sample"}, int'(out_sample), 0);
    check({tag, "_mag"},    int'(out_mag),    0);
    check({tag, "_lane"},   int'(out_lane),   0);
    check({tag, "_beat"},   int'(out_beat),   0);
    check({tag, "_len"},    int'(out_len),    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [PC*PW-1:0] pd;

  initial begin
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    p_in_valid = 1'b0; p_in_data = '0; p_in_last = 1'b0; p_out_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("rst");
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_p_valid", int'(p_out_valid), 0);
    rst_n = 1'b1;

    // Full frame
    send_beat(pack3(3, -5, 2), 1'b0);
    send_beat(pack3(1, 1, 1), 1'b0);
    send_beat(pack3(-6, 0, 4), 1'b0);
    send_beat(pack3(2, 2, 2), 1'b0);
    check("t1_valid",  int'(out_valid),  1);
    check("t1_sample", int'(out_sample), 10);
    check("t1_mag",    int'(out_mag),    6);
    check("t1_lane",   int'(out_lane),   0);
    check("t1_beat",   int'(out_beat),   2);
    check("t1_len",    int'(out_len),    4);
    @(posedge clk); #1;
    check("t1_consumed", int'(out_valid), 0);

    // Most negative and ties, early close
    send_beat(pack3(5, -5, 0), 1'b0);
    send_beat(pack3(-8, 7, -7), 1'b0);
    send_beat(pack3(-8, 0, 0), 1'b1);
    check("t2_sample", int'(out_sample), 8);
    check("t2_mag",    int'(out_mag),    8);
    check("t2_lane",   int'(out_lane),   0);
    check("t2_beat",   int'(out_beat),   1);
    check("t2_len",    int'(out_len),    3);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure
    out_ready = 1'b0;
    for (int b = 0; b < F; b++) send_beat(rand3(), 1'b0);
    check("t3_valid", int'(out_valid), 1);
    in_valid = 1'b1;
    in_data  = rand3();
    repeat (5) begin
      @(negedge clk);
      check("t3_in_ready", int'(in_ready), 0);
      check("t3_hold_valid", int'(out_valid), 1);
      check("t3_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        check("t3_hold_sample", int'(out_sample), exp_q[0].sample);
        check("t3_hold_mag",    int'(out_mag),    exp_q[0].mag);
        check("t3_hold_len",    int'(out_len),    exp_q[0].len);
      end
    end
    @(posedge clk); #1;
    in_data   = pack3(1, 0, 0);
    in_last   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t3_new_valid", int'(out_valid), 1);
    check("t3_new_mag",   int'(out_mag),   1);
    check("t3_new_len",   int'(out_len),   1);
    check("t3_new_beat",  int'(out_beat),  0);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back frames
    for (int k = 0; k < 3*F; k++) begin
      in_valid = 1'b1;
      in_data  = rand3();
      in_last  = 1'b0;
      @(negedge clk);
      check("t4_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      check("t4_out_valid", int'(out_valid), int'(((k+1) % F) == 0));
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame
    send_beat(pack3(-7, 0, 0), 1'b0);
    send_beat(pack3(-7, 0, 0), 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_zero_outputs("t5_during");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("t5_after");
    for (int b = 0; b < F; b++) send_beat(pack3(1, 2, 3), 1'b0);
    check("t5_valid",  int'(out_valid),  1);
    check("t5_sample", int'(out_sample), 3);
    check("t5_mag",    int'(out_mag),    3);
    check("t5_lane",   int'(out_lane),   2);
    check("t5_beat",   int'(out_beat),   0);
    check("t5_len",    int'(out_len),    4);
    repeat (2) @(posedge clk);
    #1;

    // Parameter sweep instance: every beat is a frame
    for (int j = 0; j < 24; j++) begin
      for (int l = 0; l < PC; l++) pd[l*PW +: PW] = 8'($urandom_range(0, 255));
      if (j == 3) begin
        for (int l = 0; l < PC; l++) pd[l*PW +: PW] = 8'(l + 1);
        pd[2*PW +: PW] = 8'h80;
      end
      if (j == 5) begin
        for (int l = 0; l < PC; l++) pd[l*PW +: PW] = 8'h80;
      end
      p_out_ready = ($urandom_range(0, 3) != 0);
      p_send(pd, 1'($urandom_range(0, 1)));
      if (j == 3) begin
        check("p_min_valid", int'(p_out_valid), 1);
        check("p_min_mag",   int'(p_out_mag),   128);
        check("p_min_lane",  int'(p_out_lane),  2);
        check("p_min_len",   int'(p_out_len),   1);
      end
      if (j == 5) begin
        check("p_tie_mag",  int'(p_out_mag),  128);
        check("p_tie_lane", int'(p_out_lane), 0);
      end
    end
    p_out_ready = 1'b1;
    out_ready   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_main", exp_q.size(), 0);
    check("drain_p",    p_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
